// File: rtl/sram_hs.sv
// sram_hs: single-port SRAM with valid/ready command and response channels,
// byte-masked writes, RD_LAT-deep response pipeline and an in-order response
// FIFO so the consumer can stall without losing data.
// Optional build macro: SRAM_HS_INIT_ZERO_EN zero-fills the array after reset.
module sram_hs #(
   parameter int DP        = 512,
   parameter int DW        = 32,
   parameter int MW        = 4,
   parameter int AW        = 32,
   parameter int RD_LAT    = 1,
   parameter int RSP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_read,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [MW-1:0] cmd_wmask,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err
);

   localparam int IW = (DP > 1) ? $clog2(DP) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   logic [DW-1:0] r_mem [DP];

   logic          r_rdy;
   logic [CW-1:0] r_cnt;
   logic          r_pv [RD_LAT];
   logic          r_pe [RD_LAT];
   logic [DW-1:0] r_pd [RD_LAT];
   logic [DW-1:0] r_fd [RSP_DEPTH];
   logic          r_fe [RSP_DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_fcnt;

   logic          w_acc;
   logic          w_pop;
   logic          w_push;
   logic          w_oor;
   logic [IW-1:0] w_idx;
   logic [DW-1:0] w_bmask;
   logic          w_init_wr;
   logic [IW-1:0] w_init_idx;

   function automatic logic [PW-1:0] f_ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_oor     = (cmd_addr >= AW'(DP));
   assign w_idx     = cmd_addr[IW-1:0];
   assign rsp_valid = (r_fcnt != '0);
   assign w_pop     = rsp_valid & rsp_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign cmd_ready = r_rdy & ((r_cnt < CW'(RSP_DEPTH)) | w_pop);
   assign w_acc     = cmd_valid & cmd_ready;
   assign w_push    = r_pv[RD_LAT-1];
   assign rsp_rdata = rsp_valid ? r_fd[r_rp] : '0;
   assign rsp_err   = rsp_valid & r_fe[r_rp];

   // expand byte enables to a per-bit mask; the top lane may be partial
   always_comb begin
      w_bmask = '0;
      for (int b = 0; b < DW; b++) begin
         if ((b / 8) < MW) w_bmask[b] = cmd_wmask[b / 8];
      end
   end

`ifdef SRAM_HS_INIT_ZERO_EN
   typedef enum logic {S_INIT, S_IDLE} state_t;
   state_t        r_state;
   logic [IW-1:0] r_init_idx;

   assign w_init_wr  = rst_n & (r_state == S_INIT);
   assign w_init_idx = r_init_idx;

   // init FSM: zero one word per cycle, then open the command port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_init_idx <= '0;
         r_rdy      <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (r_init_idx == IW'(DP - 1)) begin
                  r_state <= S_IDLE;
                  r_rdy   <= 1'b1;
               end else begin
                  r_init_idx <= r_init_idx + 1'b1;
               end
            end
            S_IDLE:  r_rdy <= 1'b1;
            default: r_state <= S_INIT;
         endcase
      end
   end
`else
   assign w_init_wr  = 1'b0;
   assign w_init_idx = '0;

   // command port opens on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdy <= 1'b0;
      else        r_rdy <= 1'b1;
   end
`endif

   // array write port: init zeroing or lane-masked command write
   always_ff @(posedge clk) begin
      if (w_init_wr) begin
         r_mem[w_init_idx] <= '0;
      end else if (w_acc && !cmd_read && !w_oor) begin
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (cmd_wdata & w_bmask);
      end
   end

   // control: pipeline valids, outstanding count, FIFO pointers/occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) r_pv[i] <= 1'b0;
         r_cnt  <= '0;
         r_fcnt <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
      end else begin
         r_pv[0] <= w_acc;
         for (int i = 1; i < RD_LAT; i++) r_pv[i] <= r_pv[i-1];
         if (w_acc && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (!w_acc && w_pop) r_cnt <= r_cnt - 1'b1;
         if (w_push && !w_pop)      r_fcnt <= r_fcnt + 1'b1;
         else if (!w_push && w_pop) r_fcnt <= r_fcnt - 1'b1;
         if (w_push) r_wp <= f_ptr_nxt(r_wp);
         if (w_pop)  r_rp <= f_ptr_nxt(r_rp);
      end
   end

   // data: sample array at accept, carry through pipeline, store into FIFO
   always_ff @(posedge clk) begin
      r_pd[0] <= (cmd_read && !w_oor) ? r_mem[w_idx] : '0;
      r_pe[0] <= w_oor;
      for (int i = 1; i < RD_LAT; i++) begin
         r_pd[i] <= r_pd[i-1];
         r_pe[i] <= r_pe[i-1];
      end
      if (w_push) begin
         r_fd[r_wp] <= r_pd[RD_LAT-1];
         r_fe[r_wp] <= r_pe[RD_LAT-1];
      end
   end

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && (r_fcnt == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_sram_hs.sv
// tb_sram_hs: scoreboard bench for sram_hs (RD_LAT=2, RSP_DEPTH=3).
module tb_sram_hs;
   localparam int DP = 512, DW = 32, MW = 4, AW = 32, RD_LAT = 2, RSP_DEPTH = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_read;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [MW-1:0] cmd_wmask;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mdl [DP];
   int            n_cmp = 0, n_bad = 0, n_acc = 0, n_pop = 0;

   sram_hs #(.DP(DP), .DW(DW), .MW(MW), .AW(AW), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: model the array at accept, compare at pop
   always @(negedge clk) begin : mon
      exp_t          e;
      logic [DW-1:0] w;
      logic          oor;
      if (rst_n) begin
         if (rsp_valid && rsp_ready) begin
            n_pop++;
            if (q.size() == 0) begin
               check("spurious_rsp", 64'(rsp_valid), 64'(0));
            end else begin
               e = q.pop_front();
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
         end
         if (cmd_valid && cmd_ready) begin
            n_acc++;
            oor     = (cmd_addr >= AW'(DP));
            e.err   = oor;
            e.rdata = '0;
            if (!oor) begin
               if (cmd_read) begin
                  e.rdata = mdl[cmd_addr[8:0]];
               end else begin
                  w = mdl[cmd_addr[8:0]];
                  for (int i = 0; i < MW; i++)
                     if (cmd_wmask[i]) w[8*i +: 8] = cmd_wdata[8*i +: 8];
                  mdl[cmd_addr[8:0]] = w;
               end
            end
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
      int t = 0;
      cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) check("send_timeout", 64'(cmd_ready), 64'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      check("drain_empty", 64'(q.size()), 64'(0));
      check("drain_idle", 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, t;
`ifdef SRAM_HS_INIT_ZERO_EN
      for (int i = 0; i < DP; i++) mdl[i] = '0;
`endif
      cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
      rsp_ready = 1'b1; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 64'(cmd_ready), 64'(0));
`ifdef SRAM_HS_INIT_ZERO_EN
      t = 0;
      while (!cmd_ready && t < DP + 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("init_cycles", 64'(t), 64'(DP));
      send(1'b1, 5, '0, '0);
      drain();
`else
      @(posedge clk);
      #1;
      check("ready_after_release", 64'(cmd_ready), 64'(1));
`endif

      // masked write merge and read latency
      send(1'b0, 3, 32'hDEADBEEF, 4'hF);
      send(1'b0, 3, 32'h11223344, 4'b0101);
      drain();
      send(1'b1, 3, '0, '0);
      check("lat_accept", 64'(rsp_valid), 64'(0));
      for (int k = 1; k < RD_LAT; k++) begin
         @(posedge clk);
         #1;
         check("lat_wait", 64'(rsp_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      check("lat_valid", 64'(rsp_valid), 64'(1));
      check("lat_rdata", 64'(rsp_rdata), 64'(32'hDE22BE44));
      drain();

      // fill words 0..7 and 88, then back-to-back reads at full rate
      for (int i = 0; i < 8; i++) send(1'b0, AW'(i), 32'hA5000000 | DW'(i * 32'h111), 4'hF);
      send(1'b0, 88, 32'h0BADF00D, 4'hF);
      drain();
      p = n_pop;
      cmd_valid = 1'b1; cmd_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_addr = AW'(i);
         @(negedge clk);
         check("b2b_ready", 64'(cmd_ready), 64'(1));
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      repeat (RD_LAT + 1) @(posedge clk);
      #1;
      check("b2b_pops", 64'(n_pop - p), 64'(8));
      drain();

      // backpressure: only RSP_DEPTH accepts, then accept alongside first pop
      rsp_ready = 1'b0;
      p = n_acc;
      cmd_valid = 1'b1; cmd_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_addr = AW'(7 - i);
         @(posedge clk);
         #1;
      end
      check("bp_accepts", 64'(n_acc - p), 64'(RSP_DEPTH));
      check("bp_ready_low", 64'(cmd_ready), 64'(0));
      cmd_addr = 88;
      rsp_ready = 1'b1;
      #1;
      check("bp_bypass_ready", 64'(cmd_ready), 64'(1));
      p = n_acc;
      @(posedge clk);
      #1;
      check("bp_accept_with_pop", 64'(n_acc - p), 64'(1));
      cmd_valid = 1'b0;
      drain();

      // out-of-range accesses leave the array untouched
      send(1'b1, 512, '0, '0);
      send(1'b0, 600, 32'hFFFFFFFF, 4'hF);
      send(1'b1, 88, '0, '0);
      drain();

      // reset with responses pending
      rsp_ready = 1'b0;
      send(1'b1, 3, '0, '0);
      send(1'b1, 88, '0, '0);
      t = 0;
      while (!rsp_valid && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("pending_before_rst", 64'(rsp_valid), 64'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(rsp_valid), 64'(0));
      check("async_rst_rdata", 64'(rsp_rdata), 64'(0));
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale_rsp", 64'(rsp_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      send(1'b1, 3, '0, '0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
